// File: rtl/mips_cpu_div_pkg.sv
// Shared definitions for the MIPS DIV/DIVU iterative divider.
// Provides the controller state type, the operand width and the number of
// restoring steps per division, plus a sign-magnitude helper.
package mips_cpu_div_pkg;

   localparam int DATA_W         = 32;
   localparam int DIV_ITERATIONS = 32;
   localparam int CNT_W          = 6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Absolute value of a two's-complement operand when treated as signed;
   // the most negative value maps onto itself, which is the correct unsigned
   // magnitude 2^(DATA_W-1).
   function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                   input logic                     is_signed);
      logic signed [DATA_W-1:0] neg;
      neg = -v;
      return (is_signed && v[DATA_W-1]) ? $unsigned(neg) : $unsigned(v);
   endfunction

endpackage

// File: rtl/mips_cpu_div_step.sv
// One restoring shift-subtract step of an unsigned division.
// Ports:
//   rem_in  - partial remainder before the step (always < divisor, or any
//             value when divisor is zero)
//   bit_in  - next dividend bit shifted into the partial remainder
//   divisor - divisor magnitude
//   rem_out - partial remainder after the step
//   q_bit   - quotient bit produced by this step
module mips_cpu_div_step
   import mips_cpu_div_pkg::*;
(
   input  logic [DATA_W-1:0] rem_in,
   input  logic              bit_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] rem_out,
   output logic              q_bit
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] diff;

   // The shifted remainder needs one extra bit: 2*rem+1 can exceed DATA_W bits.
   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {1'b0, divisor};
      q_bit   = (shifted >= {1'b0, divisor});
      rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
   end

endmodule

// File: rtl/mips_cpu_divider.sv
// MIPS DIV/DIVU multi-cycle divider (restoring, one quotient bit per cycle).
// Operands are latched as magnitudes on an accepted start, 32 steps run in
// RUN, signs are restored in FIX, and results are registered on entry to
// DONE with a one-cycle done pulse.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start               - request a division (accepted only while busy=0)
//   sign                - 1 = signed DIV, 0 = unsigned DIVU
//   dividend, divisor   - operands, captured with start
//   busy                - high while in RUN or FIX
//   done                - one-cycle pulse when quotient/remainder update
//   quotient, remainder - LO / HI results, held between completions
// Build option: define MIPS_DIV_ZERO_FAST_EN to finish a divide-by-zero in
// one cycle without ever raising busy.
module mips_cpu_divider
   import mips_cpu_div_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              sign,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

`ifdef MIPS_DIV_ZERO_FAST_EN
   localparam bit ZERO_FAST = 1'b1;
`else
   localparam bit ZERO_FAST = 1'b0;
`endif

   div_state_t        state;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] rem_work;
   logic [DATA_W-1:0] quo_work;
   logic [DATA_W-1:0] dsr_work;
   logic              neg_quo;
   logic              neg_rem;
   logic              dsr_zero;
   logic [DATA_W-1:0] step_rem;
   logic              step_bit;

   function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                    input logic              neg);
      logic signed [DATA_W-1:0] s;
      s = signed'(mag);
      return neg ? $unsigned(-s) : $unsigned(s);
   endfunction

   mips_cpu_div_step u_step (
      .rem_in  (rem_work),
      .bit_in  (quo_work[DATA_W-1]),
      .divisor (dsr_work),
      .rem_out (step_rem),
      .q_bit   (step_bit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         count     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (ZERO_FAST && divisor == '0) begin
                     quotient  <= '1;
                     remainder <= dividend;
                     done      <= 1'b1;
                     state     <= DONE;
                  end else begin
                     // The dividend register doubles as the quotient shift
                     // register: its MSB feeds each step, the new bit enters at the LSB.
                     quo_work <= magnitude(dividend, sign);
                     dsr_work <= magnitude(divisor, sign);
                     rem_work <= '0;
                     neg_quo  <= sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                     neg_rem  <= sign & dividend[DATA_W-1];
                     dsr_zero <= (divisor == '0);
                     count    <= '0;
                     busy     <= 1'b1;
                     state    <= RUN;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               rem_work <= step_rem;
               quo_work <= {quo_work[DATA_W-2:0], step_bit};
               count    <= count + CNT_W'(1);
               if (count == CNT_W'(DIV_ITERATIONS - 1)) state <= FIX;
            end
            FIX: begin
               // Divide-by-zero yields all-ones regardless of operand signs;
               // the remainder magnitude is then the dividend itself.
               quotient  <= dsr_zero ? '1 : apply_sign(quo_work, neg_quo);
               remainder <= apply_sign(rem_work, neg_rem);
               busy      <= 1'b0;
               done      <= 1'b1;
               state     <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_cpu_divider.sv
module tb_mips_cpu_divider;

`ifdef MIPS_DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        start;
   logic        sign;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int total = 0;
   int bad   = 0;

   mips_cpu_divider dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sign      (sign),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of DIV/DIVU: {quotient, remainder}
   function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb, sq, sr;
      if (b == 32'd0) return {32'hFFFF_FFFF, a};
      if (!sg) return {a / b, a % b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
      sa = signed'(a);
      sb = signed'(b);
      sq = sa / sb;
      sr = sa % sb;
      return {sq, sr};
   endfunction

   // Cycle-level expectation: an accepted start completes a fixed number of
   // edges later; outputs change only on completion or reset.
   int          m_left = 0;
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [31:0] m_q = '0;
   logic [31:0] m_r = '0;
   logic [63:0] m_pend = '0;
   logic        chk_en = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_left <= 0;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         chk_en <= 1'b1;
      end else begin
         m_done <= 1'b0;
         if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy     <= 1'b0;
               m_done     <= 1'b1;
               {m_q, m_r} <= m_pend;
            end
         end else if (start && !m_busy) begin
            if (FAST && divisor == 32'd0) begin
               m_done     <= 1'b1;
               {m_q, m_r} <= ref_div(sign, dividend, divisor);
            end else begin
               m_left <= 33;
               m_busy <= 1'b1;
               m_pend <= ref_div(sign, dividend, divisor);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'd0, busy}, {31'd0, m_busy});
         check("done", {31'd0, done}, {31'd0, m_done});
         check("quotient", quotient, m_q);
         check("remainder", remainder, m_r);
      end
   end

   // Issue one division and check its result and timing.
   // exp_lat counts edges from the accepting edge to the edge that raises done.
   task automatic run_op(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit noisy);
      int lat, bcnt, exp_lat;
      bit got;
      exp_lat = (FAST && b == 32'd0) ? 0 : 33;
      got = 1'b0; lat = 0; bcnt = 0;
      @(negedge clk);
      start = 1'b1; sign = sg; dividend = a; divisor = b;
      @(posedge clk);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            lat = k - 1;
            start = 1'b0;
            break;
         end
         if (busy) bcnt++;
         // While busy, scribble on the inputs; none of it may reach the result.
         start    = noisy && busy ? 1'($urandom) : 1'b0;
         sign     = noisy ? 1'($urandom) : sign;
         dividend = noisy ? $urandom : dividend;
         divisor  = noisy ? $urandom : divisor;
      end
      start = 1'b0;
      check({nm, "_done_seen"}, {31'd0, got}, 32'd1);
      check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
      check({nm, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
      check({nm, "_q"}, quotient, eq);
      check({nm, "_r"}, remainder, er);
   endtask

   initial begin
      int lat;
      bit got, seen;
      logic [63:0] e;
      logic sg;
      logic [31:0] a, b;

      reset = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_q", quotient, 32'd0);
      check("reset_r", remainder, 32'd0);
      reset = 1'b0;

      run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b1);
      run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
      run_op("u5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
      run_op("s_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);

      // Reset ten cycles into RUN abandons the operation.
      @(negedge clk);
      start = 1'b1; sign = 1'b0; dividend = 32'd1000; divisor = 32'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      check("rst_mid_q", quotient, 32'd0);
      check("rst_mid_r", remainder, 32'd0);
      reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("rst_mid_no_done", {31'd0, seen}, 32'd0);

      // Reset wins over a simultaneous start.
      reset = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd3;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("rst_vs_start_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("rst_vs_start_busy2", {31'd0, busy}, 32'd0);

      // start held high with changing operands: first result intact, the
      // second operation is accepted on the DONE cycle.
      @(negedge clk);
      start = 1'b1; sign = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk);
      got = 1'b0; lat = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; lat = k - 1; break; end
         sign = 1'($urandom); dividend = $urandom; divisor = $urandom | 32'd1;
      end
      check("hold_first_seen", {31'd0, got}, 32'd1);
      check("hold_first_lat", 32'(lat), 32'd33);
      check("hold_first_q", quotient, 32'd14);
      check("hold_first_r", remainder, 32'd2);
      sign = 1'b0; dividend = 32'd1000; divisor = 32'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("hold_second_busy", {31'd0, busy}, 32'd1);
      got = 1'b0; lat = 0;
      for (int k = 2; k <= 41; k++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; lat = k - 1; break; end
      end
      check("hold_second_seen", {31'd0, got}, 32'd1);
      check("hold_second_lat", 32'(lat), 32'd33);
      check("hold_second_q", quotient, 32'd333);
      check("hold_second_r", remainder, 32'd1);

      // Randomized operations with boundary-biased operands.
      for (int i = 0; i < 150; i++) begin
         sg = 1'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 5))
            0: ;
            1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
            2: b = 32'd0;
            3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            4: b = $urandom_range(0, 1) ? 32'd1 : 32'hFFFF_FFFF;
            default: begin a = -($urandom_range(1, 500)); b = $urandom_range(1, 20); end
         endcase
         e = ref_div(sg, a, b);
         run_op("rand", sg, a, b, e[63:32], e[31:0], 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_cpu_divider.md
MIPS_CPU_DIVIDER -- requirements
Module: mips_cpu_divider

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request a division; sampled only while busy=0.
REQ-004 SHALL have port: sign  input  1  1=signed (DIV), 0=unsigned (DIVU); captured with start.
REQ-005 SHALL have port: dividend  input  32  numerator; captured with start.
REQ-006 SHALL have port: divisor  input  32  denominator; captured with start.
REQ-007 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when quotient/remainder are valid.
REQ-009 SHALL have port: quotient  output  32  LO result.
REQ-010 SHALL have port: remainder  output  32  HI result.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-012 SHALL, when start=1 and busy=0 (IDLE or DONE) at edge N, capture sign, dividend and divisor magnitudes, clear the iteration counter, and enter RUN.
REQ-013 SHALL perform one restoring shift-subtract step per edge in RUN, 32 steps over edges N+1..N+32, then enter FIX.
REQ-014 SHALL, at edge N+33 (FIX->DONE), register final quotient/remainder; done=1 for exactly the cycle after N+33, then DONE->IDLE unless a new start is accepted.
REQ-015 SHALL drive busy=1 in RUN and FIX only; start while busy=1 SHALL be ignored with no effect on the in-flight operation.
REQ-016 SHALL, for sign=1, truncate the quotient toward zero; quotient negative iff operand signs differ; remainder takes the dividend sign; |remainder| < |divisor|.
REQ-017 SHALL, for sign=1, dividend=0x80000000, divisor=0xFFFFFFFF, produce quotient=0x80000000, remainder=0 (no trap).
REQ-018 SHALL, for divisor=0 (either sign), produce quotient=0xFFFFFFFF, remainder=dividend.
REQ-019 SHALL hold quotient/remainder stable between completions; in-flight working registers SHALL NOT be visible on outputs.
REQ-020 SHALL take operand values only from the start cycle; later input changes SHALL NOT affect the result.

Reset
REQ-021 SHALL, on reset=1 at any edge, enter IDLE with busy=0, done=0, quotient=0, remainder=0, counter=0.
REQ-022 SHALL, on reset mid-operation, abandon the operation with no done pulse; reset SHALL take priority over start in the same cycle.

Configuration
REQ-023 SHALL, with MIPS_DIV_ZERO_FAST_EN defined, on an accepted start with divisor=0, go straight to DONE at edge N with the REQ-018 results, done=1 in the cycle after N, busy never asserted.
REQ-024 SHALL, without MIPS_DIV_ZERO_FAST_EN, run divisor=0 through the full 33-edge RUN/FIX path with the same REQ-018 results.

Structure
REQ-025 SHALL take the state typedef (div_state_t) and constant DIV_ITERATIONS=32 from shared package mips_cpu_div_pkg.
REQ-026 SHALL place one restoring-step datapath (partial remainder, quotient bit) in combinational sub-module mips_cpu_div_step, instantiated once.

Verification
REQ-027 SHALL check: unsigned 100/7 -> quotient=14, remainder=2, done exactly 33 cycles after start edge, busy high for 33 cycles.
REQ-028 SHALL check: signed 0xFFFFFFF9(-7)/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; signed 7/0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
REQ-029 SHALL check: 0x80000000/0xFFFFFFFF signed -> 0x80000000 r 0; unsigned -> quotient=0, remainder=0x80000000.
REQ-030 SHALL check: 5/0 -> quotient=0xFFFFFFFF, remainder=5; done after 1 cycle with MIPS_DIV_ZERO_FAST_EN, 33 without.
REQ-031 SHALL check: reset asserted 10 cycles into RUN -> next cycle busy=0, done=0, outputs 0; no done pulse follows.
REQ-032 SHALL check: start=1 held with new operands throughout an operation -> first result unchanged; second operation begins on the DONE cycle, its done 33 cycles later.
